// File: rtl/packed_port_unpacker.sv
// packed_port_unpacker
// Reassembles a 12-bit word {b[10:0], c} from a framed stream of 4-bit beats
// (MSB beat first, first beat flagged by in_sof) and queues finished words in
// a first-word-fall-through FIFO with a valid/ready output.
//
// Optional feature macro: UNPACK_PARITY_EN
//   When defined, a fourth beat follows each word; its bit 0 carries even
//   parity over the 12 data bits. Words with bad parity are dropped and err
//   pulses. When undefined, a word completes on its third beat.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a beat flagged as start-of-frame
// S_COLLECT | beat0 held, r_cnt (1..2) beats of the word received so far
// S_PARITY  | all three data beats held, waiting for the parity beat
//           | (only with UNPACK_PARITY_EN)

module packed_port_unpacker #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sof,
  input  logic [3:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] out_b,
  output logic        out_c,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
`ifdef UNPACK_PARITY_EN
    S_COLLECT = 2'd1,
    S_PARITY  = 2'd2
`else
    S_COLLECT = 2'd1
`endif
  } state_t;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [3:0]  r_beat0;
  logic [3:0]  r_beat1;
`ifdef UNPACK_PARITY_EN
  logic [3:0]  r_beat2;
`endif
  logic        r_err;

  logic [11:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_out_valid;

  logic          w_full;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_bad;
  logic [11:0]   w_word;
  logic [11:0]   w_head;
  logic [CW-1:0] w_count_nxt;

  // in_ready uses the pre-pop full flag so a word is only ever assembled
  // into a slot that is already known to be free.
  assign w_full   = (r_count == CW'(DEPTH));
  assign in_ready = !w_full;
  assign w_accept = in_valid && !w_full;
  assign w_pop    = r_out_valid && out_ready;

  // Decode the accepted beat: framing/parity errors and word completion.
  always_comb begin
    w_push = 1'b0;
    w_bad  = 1'b0;
    w_word = {r_beat0, r_beat1, in_data};
    if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          if (!in_sof) w_bad = 1'b1;
        end
        S_COLLECT: begin
          if (in_sof) begin
            w_bad = 1'b1;
          end else if (r_cnt == 2'd2) begin
`ifndef UNPACK_PARITY_EN
            w_push = 1'b1;
`endif
          end
        end
`ifdef UNPACK_PARITY_EN
        S_PARITY: begin
          w_word = {r_beat0, r_beat1, r_beat2};
          if (in_sof) begin
            w_bad = 1'b1;
          end else if (in_data[0] != (^{r_beat0, r_beat1, r_beat2})) begin
            w_bad = 1'b1;
          end else begin
            w_push = 1'b1;
          end
        end
`endif
        default: begin
          w_bad = 1'b0;
        end
      endcase
    end
  end

  // Frame-assembly FSM; a sof beat always restarts the word as beat0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_beat0 <= 4'd0;
      r_beat1 <= 4'd0;
`ifdef UNPACK_PARITY_EN
      r_beat2 <= 4'd0;
`endif
      r_err   <= 1'b0;
    end else begin
      r_err <= w_bad;
      if (w_accept) begin
        if (in_sof) begin
          r_beat0 <= in_data;
          r_cnt   <= 2'd1;
          r_state <= S_COLLECT;
        end else begin
          case (r_state)
            S_COLLECT: begin
              if (r_cnt == 2'd1) begin
                r_beat1 <= in_data;
                r_cnt   <= 2'd2;
              end else begin
`ifdef UNPACK_PARITY_EN
                r_beat2 <= in_data;
                r_state <= S_PARITY;
`else
                r_state <= S_IDLE;
`endif
                r_cnt   <= 2'd0;
              end
            end
            default: begin
              r_state <= S_IDLE;
              r_cnt   <= 2'd0;
            end
          endcase
        end
      end
    end
  end

  // Next occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // FIFO pointers, occupancy and the registered valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      r_count     <= w_count_nxt;
      r_out_valid <= (w_count_nxt != '0);
    end
  end

  // FIFO storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  // Head is forced to zero when the FIFO is empty.
  assign w_head    = r_out_valid ? r_mem[r_rd_ptr] : 12'd0;
  assign out_valid = r_out_valid;
  assign out_b     = w_head[11:1];
  assign out_c     = w_head[0];
  assign err       = r_err;

endmodule
